// File: rtl/urv_imem_bridge.sv
// uRV instruction-memory responder: one-entry word buffer with a pipelined Wishbone read master.
// Optional next-word prefetch buffer enabled by defining URV_IMEM_PREFETCH_EN.
module urv_imem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic        flush_i,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        stale_q, stale_d;
    logic        cur_vld_q, cur_vld_d;
    logic [29:0] cur_tag_q, cur_tag_d;
    logic [31:0] cur_dat_q, cur_dat_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic [29:0] tag_in;
    logic        ack, berr, tmo, good, byp, cur_hit, pf_hit, miss;
    logic        unused_addr_lo;

    assign tag_in         = im_addr_i[31:2];
    assign unused_addr_lo = ^im_addr_i[1:0];

`ifdef URV_IMEM_PREFETCH_EN
    logic        pf_vld_q, pf_vld_d;
    logic [29:0] pf_tag_q, pf_tag_d;
    logic [31:0] pf_dat_q, pf_dat_d;
    logic        is_pf_q, is_pf_d;
    logic        pf_fail_q, pf_fail_d;
    logic [29:0] nxt_tag;
    assign nxt_tag = cur_tag_q + 30'd1;
    assign pf_hit  = pf_vld_q && (pf_tag_q == tag_in);
`else
    assign pf_hit  = 1'b0;
`endif

    assign ack     = (state_q == S_WAIT) && wb_ack_i;
    assign berr    = (state_q == S_WAIT) && wb_err_i;
    assign tmo     = (state_q != S_IDLE) && (cnt_q == TMO_LAST);
    // A flushed or stale read ends the cycle but must never reach the buffer.
    assign good    = ack && !stale_q && !flush_i;
    assign byp     = good && (adr_q[31:2] == tag_in);
    assign cur_hit = cur_vld_q && (cur_tag_q == tag_in);
    assign miss    = flush_i || !(byp || cur_hit || pf_hit);

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        cnt_d     = cnt_q;
        stale_d   = stale_q;
        cur_vld_d = cur_vld_q;
        cur_tag_d = cur_tag_q;
        cur_dat_d = cur_dat_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        err_d     = 1'b0;
`ifdef URV_IMEM_PREFETCH_EN
        pf_vld_d  = pf_vld_q;
        pf_tag_d  = pf_tag_q;
        pf_dat_d  = pf_dat_q;
        is_pf_d   = is_pf_q;
        pf_fail_d = pf_fail_q;
`endif

        if (flush_i) begin
            cur_vld_d = 1'b0;
`ifdef URV_IMEM_PREFETCH_EN
            pf_vld_d  = 1'b0;
            pf_fail_d = 1'b0;
`endif
        end else if (byp) begin
            valid_d = 1'b1;
            data_d  = wb_dat_i;
        end else if (cur_hit) begin
            valid_d = 1'b1;
            data_d  = cur_dat_q;
        end
`ifdef URV_IMEM_PREFETCH_EN
        else if (pf_hit) begin
            valid_d   = 1'b1;
            data_d    = pf_dat_q;
            cur_vld_d = 1'b1;
            cur_tag_d = pf_tag_q;
            cur_dat_d = pf_dat_q;
            pf_vld_d  = 1'b0;
            pf_fail_d = 1'b0;
        end
`endif

        if (good) begin
`ifdef URV_IMEM_PREFETCH_EN
            // A prefetch the core is already asking for goes straight to CUR.
            if (is_pf_q && !byp) begin
                pf_vld_d = 1'b1;
                pf_tag_d = adr_q[31:2];
                pf_dat_d = wb_dat_i;
            end else begin
                cur_vld_d = 1'b1;
                cur_tag_d = adr_q[31:2];
                cur_dat_d = wb_dat_i;
                pf_fail_d = 1'b0;
            end
`else
            cur_vld_d = 1'b1;
            cur_tag_d = adr_q[31:2];
            cur_dat_d = wb_dat_i;
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    state_d = S_REQ;
                    adr_d   = {tag_in, 2'b00};
                    cnt_d   = '0;
                    stale_d = 1'b0;
`ifdef URV_IMEM_PREFETCH_EN
                    is_pf_d = 1'b0;
                end else if (cur_hit && !pf_fail_q && !(pf_vld_q && pf_tag_q == nxt_tag)) begin
                    state_d = S_REQ;
                    adr_d   = {nxt_tag, 2'b00};
                    cnt_d   = '0;
                    stale_d = 1'b0;
                    is_pf_d = 1'b1;
`endif
                end
            end
            S_REQ, S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (flush_i) stale_d = 1'b1;
                if (tmo || berr) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
`ifdef URV_IMEM_PREFETCH_EN
                    if (is_pf_q) pf_fail_d = 1'b1;
`endif
                end else if (ack) begin
                    state_d = S_IDLE;
                end else if (state_q == S_REQ && !wb_stall_i) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            cnt_q     <= '0;
            stale_q   <= 1'b0;
            cur_vld_q <= 1'b0;
            cur_tag_q <= '0;
            cur_dat_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
`ifdef URV_IMEM_PREFETCH_EN
            pf_vld_q  <= 1'b0;
            pf_tag_q  <= '0;
            pf_dat_q  <= '0;
            is_pf_q   <= 1'b0;
            pf_fail_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            cnt_q     <= cnt_d;
            stale_q   <= stale_d;
            cur_vld_q <= cur_vld_d;
            cur_tag_q <= cur_tag_d;
            cur_dat_q <= cur_dat_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            err_q     <= err_d;
`ifdef URV_IMEM_PREFETCH_EN
            pf_vld_q  <= pf_vld_d;
            pf_tag_q  <= pf_tag_d;
            pf_dat_q  <= pf_dat_d;
            is_pf_q   <= is_pf_d;
            pf_fail_q <= pf_fail_d;
`endif
        end
    end

    assign im_valid_o = valid_q;
    assign im_data_o  = data_q;
    assign bus_err_o  = err_q;
    assign wb_adr_o   = adr_q;
    assign wb_cyc_o   = (state_q != S_IDLE);
    assign wb_stb_o   = (state_q == S_REQ);
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = 4'hF;
endmodule
